// File: rtl/dht11_pkg.sv
// DHT11 reader shared types and default timing.
// Holds the FSM state encoding and frame/timing constants.
package dht11_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START_LOW,
      WAIT_RESP,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      CHECK
   } state_t;

   localparam int FRAME_BITS = 40;
   localparam int US_W       = 16;

   localparam int CLK_FREQ_HZ_DEF   = 100_000_000;
   localparam int START_LOW_US_DEF  = 18000;
   localparam int TIMEOUT_US_DEF    = 200;
   localparam int BIT_THRESH_US_DEF = 45;

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond prescaler for the DHT11 reader.
// Ports: clk_100Mhz, rst_n in; tick out (1 cycle per CLKS_PER_US clocks).
module dht11_us_tick #(
   parameter int CLKS_PER_US = 100
) (
   input  logic clk_100Mhz,
   input  logic rst_n,
   output logic tick
);

   localparam int W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS_PER_US - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
         tick  <= 1'b1;
      end else begin
         cnt_q <= cnt_q + W'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: start pulse, 40-bit decode, checksum.
// Ports: clk_100Mhz, rst_n, start in; dht_data inout; temperature,
// humidity (8b), data_valid, busy, checksum_error, timeout_error out.
module dht11_reader
   import dht11_pkg::*;
#(
   parameter int CLK_FREQ_HZ   = CLK_FREQ_HZ_DEF,
   parameter int START_LOW_US  = START_LOW_US_DEF,
   parameter int TIMEOUT_US    = TIMEOUT_US_DEF,
   parameter int BIT_THRESH_US = BIT_THRESH_US_DEF
) (
   input  logic       clk_100Mhz,
   input  logic       rst_n,
   input  logic       start,
   inout  wire        dht_data,
   output logic [7:0] temperature,
   output logic [7:0] humidity,
   output logic       data_valid,
   output logic       busy,
   output logic       checksum_error,
   output logic       timeout_error
);

   localparam int CLKS_PER_US = CLK_FREQ_HZ / 1_000_000;

   localparam logic [US_W-1:0] START_CNT = US_W'(START_LOW_US);
   localparam logic [US_W-1:0] TO_CNT    = US_W'(TIMEOUT_US);
   localparam logic [US_W-1:0] THR_CNT   = US_W'(BIT_THRESH_US);
   localparam logic [5:0]      LAST_BIT  = 6'(FRAME_BITS - 1);

   state_t state_q, state_d;

   logic                  tick;
   logic [1:0]            sync_q;
   logic                  prev_q;
   logic                  bus_s;
   logic                  rise;
   logic                  fall;
   logic [US_W-1:0]       us_cnt_q;
   logic [5:0]            bit_cnt_q;
   logic [FRAME_BITS-1:0] shift_q;
   logic                  sensor_phase;
   logic                  timed_out;
   logic [7:0]            b0, b1, b2, b3, b4;
   logic [7:0]            sum;

   assign dht_data = (state_q == START_LOW) ? 1'b0 : 1'bz;
   assign busy     = (state_q != IDLE);

   dht11_us_tick #(
      .CLKS_PER_US(CLKS_PER_US)
   ) u_tick (
      .clk_100Mhz(clk_100Mhz),
      .rst_n     (rst_n),
      .tick      (tick)
   );

   // Idle bus is high; reset the synchronizer high so no false edge
   // appears when the first transaction starts.
   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], dht_data};
         prev_q <= sync_q[1];
      end
   end

   assign bus_s = sync_q[1];
   assign rise  = bus_s & ~prev_q;
   assign fall  = ~bus_s & prev_q;

   assign sensor_phase = state_q inside
      {WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH};
   assign timed_out = sensor_phase && (us_cnt_q >= TO_CNT);

   assign b0  = shift_q[39:32];
   assign b1  = shift_q[31:24];
   assign b2  = shift_q[23:16];
   assign b3  = shift_q[15:8];
   assign b4  = shift_q[7:0];
   assign sum = b0 + b1 + b2 + b3;

   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // WAIT_RESP looks for a falling edge: the synchronized bus still
   // reads low for a few cycles after the host releases it.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (start) state_d = START_LOW;
         START_LOW: if (us_cnt_q >= START_CNT) state_d = WAIT_RESP;
         WAIT_RESP: if (fall) state_d = RESP_LOW;
         RESP_LOW:  if (rise) state_d = RESP_HIGH;
         RESP_HIGH: if (fall) state_d = BIT_LOW;
         BIT_LOW:   if (rise) state_d = BIT_HIGH;
         BIT_HIGH: begin
            if (fall) begin
               if (bit_cnt_q == LAST_BIT) state_d = CHECK;
               else                       state_d = BIT_LOW;
            end
         end
         CHECK:     state_d = IDLE;
         default:   state_d = IDLE;
      endcase
      if (timed_out) state_d = IDLE;
   end

   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         us_cnt_q       <= '0;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         temperature    <= '0;
         humidity       <= '0;
         data_valid     <= 1'b0;
         checksum_error <= 1'b0;
         timeout_error  <= 1'b0;
      end else begin
         data_valid     <= 1'b0;
         checksum_error <= 1'b0;
         timeout_error  <= 1'b0;

         if (state_q == IDLE || state_q != state_d)
            us_cnt_q <= '0;
         else if (tick)
            us_cnt_q <= us_cnt_q + 16'd1;

         if (timed_out) begin
            timeout_error <= 1'b1;
         end else begin
            if (state_q == RESP_HIGH && fall)
               bit_cnt_q <= '0;
            if (state_q == BIT_HIGH && fall) begin
               shift_q   <= {shift_q[FRAME_BITS-2:0],
                             (us_cnt_q > THR_CNT)};
               bit_cnt_q <= bit_cnt_q + 6'd1;
            end
         end

         if (state_q == CHECK) begin
            if (sum == b4) begin
               humidity    <= b0;
               temperature <= b2;
               data_valid  <= 1'b1;
            end else begin
               checksum_error <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/dht11_reader.md
Name: dht11_reader

Overview:
- Upstream stage of the UART telemetry block. It drives the DHT11 single-wire bus and decodes the 40-bit frame.
- After checksum validation it presents integer temperature and humidity bytes, which feed the UART sender's `temperature`/`humidity` inputs directly.
- One read transaction runs per `start` pulse; the last good values are held between reads.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency; derives CLKS_PER_US = CLK_FREQ_HZ/1_000_000.
- START_LOW_US, 18000, host start-pulse low time in µs; benches override it to a small value.
- TIMEOUT_US, 200, maximum duration of any single sensor-driven phase before abort.
- BIT_THRESH_US, 45, a data-bit high time strictly greater than this decodes as 1.

Ports:
- clk_100Mhz  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a read; ignored while busy
- dht_data  inout  1  sensor bus; driven 0 when the host pulls low, otherwise high-Z (external pull-up)
- temperature  out  8  integer °C from the last valid frame
- humidity  out  8  integer %RH from the last valid frame
- data_valid  out  1  one-cycle pulse when new values are latched
- busy  out  1  high from accepting start until return to IDLE
- checksum_error  out  1  one-cycle pulse on checksum mismatch
- timeout_error  out  1  one-cycle pulse on any phase timeout

Behaviour:
- Reset (async, immediate): state=IDLE, bus released (high-Z), temperature=0, humidity=0, busy=0, all pulses 0, counters 0, shift register 0.
- Bus input: passed through a 2-flop synchronizer; all decisions use the synchronized value, adding 2 cycles of latency.
- µs tick: prescaler counts 0..CLKS_PER_US-1 and emits a 1-cycle tick at wrap. A phase µs counter clears on every state change and increments on tick.
- IDLE: on start → START_LOW, busy=1.
- START_LOW: drive bus 0. When the µs count reaches START_LOW_US → WAIT_RESP and release the bus.
- WAIT_RESP: wait for the synchronized bus to go low → RESP_LOW.
- RESP_LOW: wait for rising edge → RESP_HIGH.
- RESP_HIGH: wait for falling edge → BIT_LOW, bit_cnt=0.
- BIT_LOW: wait for rising edge → BIT_HIGH.
- BIT_HIGH: on falling edge, shift in bit = (µs count > BIT_THRESH_US), MSB first, and increment bit_cnt. If bit_cnt reaches 40 → CHECK, else → BIT_LOW.
- Timeout: in every state from WAIT_RESP through BIT_HIGH, µs count ≥ TIMEOUT_US → pulse timeout_error, go to IDLE, busy=0, outputs unchanged.
- CHECK (1 cycle): frame bytes are b0=hum_int, b1=hum_dec, b2=temp_int, b3=temp_dec, b4=checksum. Compute (b0+b1+b2+b3) mod 256 in 8-bit wrap arithmetic.
  - Equal to b4: humidity←b0, temperature←b2, pulse data_valid.
  - Not equal: pulse checksum_error, outputs unchanged.
  - Either case → IDLE, busy=0 the following cycle.
- start asserted while busy: ignored, no queuing. start on the same cycle busy falls: ignored; start must arrive while the FSM is in IDLE.
- Sensor's trailing 50 µs low after bit 40 is not awaited; the next start re-arms the FSM.
- At most one of data_valid, checksum_error, timeout_error pulses per transaction.
- Host bus drive occurs only in START_LOW. Reset during any state releases the bus in the same instant.
- Read-rate limiting (≥1 s between reads per the DHT11 datasheet) is the scheduler's responsibility, not this block's.

Decomposition:
- Package dht11_pkg holds:
  - state enum: IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK;
  - FRAME_BITS=40;
  - default timing constants.
- One sub-module, dht11_us_tick: the prescaler producing the µs tick; parameter CLKS_PER_US.
- Synchronizer, edge detect, FSM and checksum stay in dht11_reader.

Test Plan:
- Good frame (START_LOW_US=50, sensor model): bytes 55,0,24,0,79 → after CHECK, humidity=55, temperature=24, data_valid pulses once, busy falls, bus driven low only during START_LOW.
- Bad checksum: bytes 55,0,24,0,80 → checksum_error pulse; humidity and temperature keep their previous values (55/24, or 0/0 after reset); no data_valid.
- No sensor (bus stays high) → timeout_error pulse TIMEOUT_US µs after release, busy=0. Repeat with the sensor stopping mid-bit 17 (high stuck) → timeout_error.
- Bit thresholds: every bit high 28 µs → all zeros, frame 0,0,0,0,0 valid. Every bit high 70 µs → 255,255,255,255 with checksum 0xFC mismatch → checksum_error.
- start pulsed while busy at bit 10 → ignored, transaction completes normally, exactly one data_valid.
- rst_n asserted during BIT_HIGH → bus immediately high-Z, outputs 0, state IDLE. A new start after deassertion performs a full valid read (e.g. 40,0,30,0,70 → humidity=40, temperature=30).
